clock_display_ctrl: RTL

//  Settable 24h/12h time-of-day clock with a multiplexed 6-digit 7-segment driver.

---
 rtl/clock_display_ctrl_if.sv | 22 ++
 rtl/clock_display_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_ctrl_if.sv
// Board-side signal bundle for the time-of-day clock: control inputs and the
// multiplexed 7-segment outputs.
interface clock_display_ctrl_if;
  logic       run;
  logic       btn_mode;
  logic       btn_inc;
  logic       mode_12h;
  logic [7:0] number;
  logic [5:0] digit_block;
  logic       second_pulse;
  logic [1:0] field;

  modport master (
    output run, btn_mode, btn_inc, mode_12h,
    input  number, digit_block, second_pulse, field
  );

  modport slave (
    input  run, btn_mode, btn_inc, mode_12h,
    output number, digit_block, second_pulse, field
  );
endinterface

// File: rtl/clock_display_ctrl.sv
// Settable 24h clock with a 12h display option, set-time FSM with field blink
// and a registered 6-digit multiplexed 7-segment driver.
module clock_display_ctrl #(
  parameter int unsigned TICK_DIV         = 50_000_000,
  parameter int unsigned SCAN_DIV         = 50_000,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  clock_display_ctrl_if.slave bus
);

  localparam int unsigned HalfDiv = TICK_DIV / 2;
  localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BlinkW  = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;
  localparam int unsigned ScanW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [7:0] SegOff   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0] DigReset = DIGIT_ACTIVE_LOW ? 6'b111110 : 6'b000001;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSetH = 2'd1,
    StSetM = 2'd2,
    StSetS = 2'd3
  } state_e;

  state_e            state_q;
  logic [TickW-1:0]  presc_q;
  logic [5:0]        hour_q, min_q, sec_q;
  logic              second_pulse_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_q;
  logic [ScanW-1:0]  scan_cnt_q;
  logic [2:0]        scan_idx_q;
  logic [7:0]        number_q;
  logic [5:0]        digit_q;

  logic tick;
  assign tick = (state_q == StRun) && bus.run && (presc_q == TickW'(TICK_DIV - 1));

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50)      return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    logic [5:0] t6;
    logic [5:0] r;
    t6 = {2'b00, tens_of(v)};
    r  = v - (t6 << 3) - (t6 << 1);
    return r[3:0];
  endfunction

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Time-keeping and set-time FSM; state doubles as the field output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StRun;
      presc_q        <= '0;
      hour_q         <= '0;
      min_q          <= '0;
      sec_q          <= '0;
      second_pulse_q <= 1'b0;
    end else begin
      second_pulse_q <= tick;
      if (tick) begin
        presc_q <= '0;
        if (sec_q == 6'd59) begin
          sec_q <= '0;
          if (min_q == 6'd59) begin
            min_q  <= '0;
            hour_q <= (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
          end else begin
            min_q <= min_q + 6'd1;
          end
        end else begin
          sec_q <= sec_q + 6'd1;
        end
      end else if ((state_q == StRun) && bus.run) begin
        presc_q <= presc_q + TickW'(1);
      end

      unique case (state_q)
        StRun: begin
          if (bus.btn_mode) state_q <= StSetH;
        end
        StSetH: begin
          if (bus.btn_mode) state_q <= StSetM;
          else if (bus.btn_inc) hour_q <= (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
        end
        StSetM: begin
          if (bus.btn_mode) state_q <= StSetS;
          else if (bus.btn_inc) min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
        StSetS: begin
          if (bus.btn_mode) begin
            state_q <= StRun;
            presc_q <= '0;
          end else if (bus.btn_inc) begin
            sec_q <= (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Free-running blink phase, independent of the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(HalfDiv - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BlinkW'(1);
    end
  end

  logic [2:0] idx_next;
  logic [5:0] hr_mod, hour_disp;
  logic [3:0] digit_val;
  logic       blank, dp, blink_hit;
  logic [7:0] seg_next;
  logic [5:0] digit_next;

  // Content for the slot that becomes active next, so segments and enable switch together.
  always_comb begin
    idx_next  = (scan_idx_q == 3'd5) ? 3'd0 : scan_idx_q + 3'd1;
    hr_mod    = (hour_q >= 6'd12) ? hour_q - 6'd12 : hour_q;
    hour_disp = bus.mode_12h ? ((hr_mod == 6'd0) ? 6'd12 : hr_mod) : hour_q;
    digit_val = 4'd0;
    blank     = 1'b0;
    dp        = 1'b0;
    case (idx_next)
      3'd0: digit_val = units_of(sec_q);
      3'd1: digit_val = tens_of(sec_q);
      3'd2: digit_val = units_of(min_q);
      3'd3: digit_val = tens_of(min_q);
      3'd4: begin
        digit_val = units_of(hour_disp);
        dp        = bus.mode_12h && (hour_q >= 6'd12);
      end
      3'd5: begin
        digit_val = tens_of(hour_disp);
        blank     = bus.mode_12h && (hour_disp < 6'd10);
      end
      default: blank = 1'b1;
    endcase
    blink_hit = ((state_q == StSetS) && (idx_next <= 3'd1)) ||
                ((state_q == StSetM) && ((idx_next == 3'd2) || (idx_next == 3'd3))) ||
                ((state_q == StSetH) && (idx_next >= 3'd4));
    if (blink_q && blink_hit) blank = 1'b1;
    seg_next   = blank ? 8'h00 : (seg_lut(digit_val) | {dp, 7'b0});
    digit_next = 6'(6'd1 << idx_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      number_q   <= SegOff;
      digit_q    <= DigReset;
    end else if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      scan_idx_q <= idx_next;
      number_q   <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
      digit_q    <= DIGIT_ACTIVE_LOW ? ~digit_next : digit_next;
    end else begin
      scan_cnt_q <= scan_cnt_q + ScanW'(1);
    end
  end

  assign bus.number       = number_q;
  assign bus.digit_block  = digit_q;
  assign bus.second_pulse = second_pulse_q;
  assign bus.field        = state_q;

endmodule
